data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder for the RISC-V pipeline's MEM stage: consumes the `MemRead`/`MemWrite` strobes, the load/store `funct3` and the ALU-computed address, and performs the access to an internal word-organised data store. It supports byte, half and word loads and stores, with sign or zero extension on loads. It models a multi-cycle read port by stalling the pipeline for a programmable latency. Misaligned or illegal accesses are rejected and flagged.

## Interface
- `ADDR_W`, default 9: word-address bits; store depth is 2^ADDR_W 32-bit words.
- `RD_LAT`, default 2: read latency in cycles, legal range 1..4.
- `clk`  in  1: the only clock; everything is rising-edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `MemRead`  in  1: load request.
- `MemWrite`  in  1: store request.
- `funct3`  in  3: access size and extension.
  - 000 = lb/sb; 001 = lh/sh; 010 = lw/sw; 100 = lbu; 101 = lhu.
- `addr`  in  32: byte address.
- `wdata`  in  32: store data, taken from the low bytes.
- `rdata`  out  32: extended load result; holds until the next load completes.
- `rdata_valid`  out  1: one-cycle pulse when `rdata` carries a new load result.
- `stall`  out  1: freeze the upstream pipeline. Upstream holds all inputs stable while this is high.
- `access_fault`  out  1: one-cycle pulse for a rejected request.

## Operation
- **Addressing**
  - Word index = `addr[ADDR_W+1:2]`. Upper address bits are ignored, so addresses wrap modulo the store size.
  - Byte lane = `addr[1:0]`.
- **Request rules (sampled in IDLE)**
  - `MemRead` and `MemWrite` both high is illegal: no access, fault.
  - Store with `funct3` > 010 is illegal: no access, fault.
  - Load with `funct3` of 011, 110 or 111 is illegal: no access, fault.
  - Word access with `addr[1:0]` != 0 is misaligned: no access, fault.
  - Half access with `addr[0]` = 1 is misaligned: no access, fault.
- **Stores**
  - Byte-enable write at the sampling edge: sb writes lane `addr[1:0]` with `wdata[7:0]`.
  - sh writes lanes {1,0} or {3,2} with `wdata[15:0]`.
  - sw writes all four lanes.
  - Untouched lanes are preserved. A store never stalls.
- **Loads**
  - The full word is captured into a holding register at the sampling edge.
  - The result is extracted from the addressed lane: lb/lh sign-extend, lbu/lhu zero-extend.
- **FSM**
  - IDLE: on a legal load, go to WAIT with `cnt` = RD_LAT-1. All other requests stay in IDLE.
  - WAIT: while `cnt` != 0, decrement. At `cnt` = 0, update `rdata`, pulse `rdata_valid`, and return to IDLE at the next edge.
  - No new request is accepted outside IDLE.
- **Stall**
  - Combinational: `stall` = (IDLE & legal load) | (WAIT & `cnt` != 0).
  - `stall` is forced 0 while `rst_n` is low.
- **Fault**
  - `access_fault` is registered: it pulses in the cycle after the faulting request's edge.
  - The store is not modified and `rdata` is unchanged.

## Timing
- **Reset values:** state IDLE, `cnt` 0, `rdata` 0, `rdata_valid` 0, `access_fault` 0, `stall` 0. Store contents are not reset.
- **Load latency**
  - Load presented in cycle 0: `stall` is high in cycles 0..RD_LAT-1.
  - In cycle RD_LAT: `stall` is 0, and `rdata`/`rdata_valid` are valid.
  - The pipeline advances at the end of cycle RD_LAT. Total occupancy is RD_LAT+1 cycles.
- **Store:** takes effect at the end of cycle 0. A load of the same word in cycle 1 returns the new data.
- **Back-to-back:**
  - A load presented in the cycle right after a completed load (state IDLE) is accepted immediately.
  - Back-to-back stores commit one per cycle.
- **Reset mid-load:** returns to IDLE asynchronously. No `rdata_valid` is produced and `rdata` is cleared to 0.
- **RD_LAT = 1:** the WAIT state is entered with `cnt` = 0. `stall` lasts exactly one cycle.

## Test plan
- **Reset:** assert `rst_n`=0 with `MemRead`=1.
  - Required: all outputs 0 and `stall`=0.
  - Release `rst_n`: `stall` rises in the same cycle.
- **Store then load, word (RD_LAT=2):** sw `wdata`=0xDEADBEEF to `addr` 0x10, then lw 0x10.
  - Required: `stall` high 2 cycles.
  - Required: `rdata`=0xDEADBEEF with a `rdata_valid` pulse in cycle 2.
- **Sub-word accesses:** sb 0x80 to 0x13, then sh 0x1234 to 0x10.
  - lb 0x13 → 0xFFFFFF80; lbu 0x13 → 0x00000080.
  - lh 0x10 → 0x00001234; lw 0x10 → 0x80AD1234.
- **Faults:**
  - lw 0x11 → `access_fault` pulse, no stall, `rdata` unchanged.
  - sh 0x13 → fault, and memory is unchanged on readback.
  - `MemRead` and `MemWrite` both high → fault.
  - load with `funct3`=011 → fault.
- **Wrap-around (ADDR_W=9):** sw 0xA5A5A5A5 to 0x800, then lw 0x000.
  - Required: returns 0xA5A5A5A5.
- **Reset mid-load:** pulse `rst_n` low in cycle 1 of a lw.
  - Required: no `rdata_valid`, `rdata`=0, FSM back in IDLE.
  - Required: the next lw completes normally.

Source files
------------

// File: rtl/data_mem_responder.sv
// MEM-stage data memory: byte/half/word loads and stores on a word-organised store,
// with a programmable read latency that stalls the pipeline and a fault pulse for rejected requests.
module data_mem_responder #(
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        stall,
    output logic        access_fault
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    logic [31:0] mem [DEPTH];

    state_t state, next_state;
    logic [1:0]  cnt, next_cnt;
    logic        stall_raw;

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]  lane;
    logic        f3_load_ok, f3_store_ok, aligned;
    logic        req_load_ok, req_store_ok, req_fault;
    logic        accept_load, accept_store, fault_now;

    logic [3:0]  be;
    logic [31:0] wword;

    logic [31:0] hold_word, rdata_reg, shifted, load_result;
    logic [1:0]  hold_lane;
    logic [2:0]  hold_f3;

    // Upper address bits are deliberately ignored so accesses wrap modulo the store size.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_W+2];

    assign word_idx = addr[ADDR_W+1:2];
    assign lane     = addr[1:0];

    always_comb begin
        f3_load_ok  = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        f3_store_ok = (funct3 <= 3'b010);
        case (funct3[1:0])
            2'b10:   aligned = (lane == 2'b00);
            2'b01:   aligned = ~lane[0];
            default: aligned = 1'b1;
        endcase
        req_load_ok  = MemRead & ~MemWrite & f3_load_ok & aligned;
        req_store_ok = MemWrite & ~MemRead & f3_store_ok & aligned;
        req_fault    = (MemRead | MemWrite) & ~req_load_ok & ~req_store_ok;
        accept_load  = (state == S_IDLE) & req_load_ok;
        accept_store = (state == S_IDLE) & req_store_ok;
        fault_now    = (state == S_IDLE) & req_fault;
    end

    always_comb begin
        be    = 4'b0000;
        wword = wdata;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << lane;
                wword = {4{wdata[7:0]}};
            end
            2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wword = wdata;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        stall_raw  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept_load) begin
                    next_state = S_WAIT;
                    next_cnt   = CNT_INIT;
                    stall_raw  = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt != 2'd0) begin
                    next_cnt  = cnt - 2'd1;
                    stall_raw = 1'b1;
                end else begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign stall       = stall_raw & rst_n;
    assign rdata_valid = (state == S_WAIT) && (cnt == 2'd0);

    always_comb begin
        shifted = hold_word >> {hold_lane, 3'b000};
        case (hold_f3)
            3'b000:  load_result = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_result = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_result = {24'b0, shifted[7:0]};
            3'b101:  load_result = {16'b0, shifted[15:0]};
            default: load_result = hold_word;
        endcase
    end

    // The completing cycle shows the fresh result directly; the register keeps it afterwards.
    assign rdata = rdata_valid ? load_result : rdata_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_word    <= 32'd0;
            hold_lane    <= 2'd0;
            hold_f3      <= 3'd0;
            rdata_reg    <= 32'd0;
            access_fault <= 1'b0;
        end else begin
            access_fault <= fault_now;
            if (accept_load) begin
                hold_word <= mem[word_idx];
                hold_lane <= lane;
                hold_f3   <= funct3;
            end
            if (rdata_valid) begin
                rdata_reg <= load_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept_store && rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a table of load/store/fault vectors plus
// hand-written reset sequences, all with hand-computed expected results.
module tb_data_mem_responder;

    localparam int RD_LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        stall;
    logic        access_fault;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_last = 32'd0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic        fault;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    data_mem_responder #(.ADDR_W(9), .RD_LAT(RD_LAT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .funct3(funct3),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata),
        .rdata_valid(rdata_valid),
        .stall(stall),
        .access_fault(access_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        funct3   = 3'b000;
        addr     = 32'd0;
        wdata    = 32'd0;
    endtask

    // Entered just after a rising edge with the FSM idle; leaves it the same way.
    task automatic applyStimulus(input vec_t v);
        int cycles;
        MemRead  = v.rd;
        MemWrite = v.wr;
        funct3   = v.f3;
        addr     = v.a;
        wdata    = v.wd;
        #1;
        if (v.rd && !v.wr && !v.fault) begin
            checkOutput({v.name, "_stall0"}, 32'(stall), 32'd1);
            cycles = 0;
            while (stall && cycles < 20) begin
                @(posedge clk);
                #1;
                cycles++;
            end
            checkOutput({v.name, "_lat"}, 32'(cycles), 32'(RD_LAT));
            checkOutput({v.name, "_valid"}, 32'(rdata_valid), 32'd1);
            checkOutput({v.name, "_rdata"}, rdata, v.exp);
            exp_last = v.exp;
            @(posedge clk);
            #1;
            idleInputs();
            checkOutput({v.name, "_validoff"}, 32'(rdata_valid), 32'd0);
            checkOutput({v.name, "_hold"}, rdata, v.exp);
            checkOutput({v.name, "_nofault"}, 32'(access_fault), 32'd0);
        end else begin
            checkOutput({v.name, "_nostall"}, 32'(stall), 32'd0);
            @(posedge clk);
            #1;
            idleInputs();
            checkOutput({v.name, "_fault"}, 32'(access_fault), 32'(v.fault));
            checkOutput({v.name, "_novalid"}, 32'(rdata_valid), 32'd0);
            checkOutput({v.name, "_rdkeep"}, rdata, exp_last);
        end
        #1;
    endtask

    initial begin
        int n;
        int pulses;

        vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        "sw_10"});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, "lw_10a"});
        vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h13,  32'h80,       1'b0, 32'h0,        "sb_13"});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h10,  32'h1234,     1'b0, 32'h0,        "sh_10"});
        vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h13,  32'h0,        1'b0, 32'hFFFFFF80, "lb_13"});
        vecs.push_back('{1'b1, 1'b0, 3'b100, 32'h13,  32'h0,        1'b0, 32'h00000080, "lbu_13"});
        vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h10,  32'h0,        1'b0, 32'h00001234, "lh_10"});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'h80AD1234, "lw_10b"});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h11,  32'h0,        1'b1, 32'h0,        "lw_mis"});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h13,  32'hFFFF,     1'b1, 32'h0,        "sh_mis"});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'h80AD1234, "lw_10c"});
        vecs.push_back('{1'b1, 1'b1, 3'b010, 32'h10,  32'h55555555, 1'b1, 32'h0,        "rdwr"});
        vecs.push_back('{1'b1, 1'b0, 3'b011, 32'h10,  32'h0,        1'b1, 32'h0,        "ld_f3_011"});
        vecs.push_back('{1'b0, 1'b1, 3'b100, 32'h10,  32'h0,        1'b1, 32'h0,        "st_f3_100"});
        vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h11,  32'h0,        1'b1, 32'h0,        "lh_mis"});
        vecs.push_back('{1'b1, 1'b0, 3'b101, 32'h12,  32'h0,        1'b0, 32'h000080AD, "lhu_12"});
        vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h12,  32'h0,        1'b0, 32'hFFFF80AD, "lh_12"});
        vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h11,  32'h0,        1'b0, 32'h00000012, "lb_11"});
        vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h800, 32'hA5A5A5A5, 1'b0, 32'h0,        "sw_800"});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h000, 32'h0,        1'b0, 32'hA5A5A5A5, "lw_wrap"});
        vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h20,  32'h11223344, 1'b0, 32'h0,        "sw_20"});
        vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h21,  32'h000000AA, 1'b0, 32'h0,        "sb_21"});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h22,  32'h0000BEEF, 1'b0, 32'h0,        "sh_22"});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h20,  32'h0,        1'b0, 32'hBEEFAA44, "lw_20"});
        vecs.push_back('{1'b1, 1'b0, 3'b101, 32'h22,  32'h0,        1'b0, 32'h0000BEEF, "lhu_22"});

        // Reset held with a legal load pending: everything must stay quiet.
        rst_n    = 1'b0;
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        funct3   = 3'b010;
        addr     = 32'h10;
        wdata    = 32'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        checkOutput("rst_valid", 32'(rdata_valid), 32'd0);
        checkOutput("rst_fault", 32'(access_fault), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rel_stall", 32'(stall), 32'd1);
        n = 0;
        while (stall && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("rel_lat", 32'(n), 32'(RD_LAT));
        @(posedge clk);
        #1;
        idleInputs();
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset pulse in cycle 1 of a word load aborts it without a result.
        MemRead = 1'b1;
        funct3  = 3'b010;
        addr    = 32'h10;
        @(posedge clk);
        #1;
        checkOutput("mid_stall1", 32'(stall), 32'd1);
        rst_n = 1'b0;
        idleInputs();
        #1;
        checkOutput("mid_rst_stall", 32'(stall), 32'd0);
        checkOutput("mid_rst_rdata", rdata, 32'd0);
        checkOutput("mid_rst_valid", 32'(rdata_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            if (rdata_valid) pulses++;
            @(posedge clk);
            #1;
        end
        checkOutput("mid_no_valid", 32'(pulses), 32'd0);
        checkOutput("mid_rdata0", rdata, 32'd0);
        checkOutput("mid_idle", 32'(stall), 32'd0);
        exp_last = 32'd0;
        applyStimulus('{1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h80AD1234, "lw_after_rst"});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got 0x00000001 expected 0x00000000");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
